// File: rtl/gmii_probe_rx.sv
// gmii_probe_rx: GMII receive-side checker for latency-probe frames.
// It finds the preamble and SFD, counts frame bytes and checks the FCS residue.
// It also pulls the magic word and timestamp out of the frame.
// For a good probe it reports latency = timer at stamp arrival - embedded stamp.
module gmii_probe_rx #(
  parameter logic [31:0] MAGIC     = 32'hDEADBEEF,
  parameter int          MAGIC_OFS = 42,
  parameter int          STAMP_OFS = 46,
  parameter int          MIN_LEN   = 64,
  parameter int          MAX_LEN   = 1518
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  input  logic [31:0] timer,
  output logic [31:0] latency,
  output logic        lat_valid,
  output logic [15:0] good_cnt,
  output logic [15:0] crc_err_cnt,
  output logic [15:0] len_err_cnt
);

  localparam logic [15:0] MAGIC_LO = 16'(MAGIC_OFS);
  localparam logic [15:0] MAGIC_HI = 16'(MAGIC_OFS + 3);
  localparam logic [15:0] STAMP_LO = 16'(STAMP_OFS);
  localparam logic [15:0] STAMP_HI = 16'(STAMP_OFS + 3);
  localparam logic [15:0] MIN_CNT  = 16'(MIN_LEN);
  localparam logic [15:0] MAX_CNT  = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        dv_d;
  logic [2:0]  pre_cnt;
  logic [15:0] byte_cnt;
  logic [31:0] crc;
  logic [31:0] magic_word;
  logic [31:0] stamp;
  logic [31:0] t_arr;

  logic        frame_start;
  logic        byte_accept;
  logic        frame_end;
  logic        too_long;
  logic        pre_inc;

  // Reflected CRC-32 (poly 04C11DB7), one byte per call, LSB first.
  function automatic logic [31:0] crc_next(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // State register. Only a rising edge of rx_dv can start a frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode. It also decodes the per-cycle datapath strobes.
  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    byte_accept = 1'b0;
    frame_end   = 1'b0;
    too_long    = 1'b0;
    pre_inc     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_dv && !dv_d) begin
          next_state = (rx_data == 8'h55) ? PRE : DROP;
        end
      end
      PRE: begin
        if (!rx_dv) begin
          next_state = IDLE;
        end else if (rx_data == 8'h55) begin
          if (pre_cnt == 3'd7) begin
            next_state = DROP;
          end else begin
            pre_inc = 1'b1;
          end
        end else if (rx_data == 8'hD5) begin
          next_state  = DATA;
          frame_start = 1'b1;
        end else begin
          next_state = DROP;
        end
      end
      DATA: begin
        if (!rx_dv) begin
          next_state = IDLE;
          frame_end  = 1'b1;
        end else begin
          byte_accept = 1'b1;
          if (byte_cnt == MAX_CNT) begin
            too_long   = 1'b1;
            next_state = DROP;
          end
        end
      end
      DROP: begin
        if (!rx_dv) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Frame datapath: CRC, byte count, field capture, evaluation and counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dv_d        <= 1'b1;
      pre_cnt     <= 3'd1;
      byte_cnt    <= 16'd0;
      crc         <= 32'hFFFFFFFF;
      magic_word  <= 32'd0;
      stamp       <= 32'd0;
      t_arr       <= 32'd0;
      latency     <= 32'd0;
      lat_valid   <= 1'b0;
      good_cnt    <= 16'd0;
      crc_err_cnt <= 16'd0;
      len_err_cnt <= 16'd0;
    end else begin
      dv_d      <= rx_dv;
      lat_valid <= 1'b0;

      if (state == IDLE) begin
        pre_cnt <= 3'd1;
      end else if (pre_inc) begin
        pre_cnt <= pre_cnt + 3'd1;
      end

      if (frame_start) begin
        byte_cnt   <= 16'd0;
        crc        <= 32'hFFFFFFFF;
        magic_word <= 32'd0;
        stamp      <= 32'd0;
      end

      if (byte_accept) begin
        crc      <= crc_next(crc, rx_data);
        byte_cnt <= byte_cnt + 16'd1;
        if (byte_cnt >= MAGIC_LO && byte_cnt <= MAGIC_HI) begin
          magic_word <= {magic_word[23:0], rx_data};
        end
        if (byte_cnt >= STAMP_LO && byte_cnt <= STAMP_HI) begin
          stamp <= {stamp[23:0], rx_data};
        end
        if (byte_cnt == STAMP_HI) begin
          t_arr <= timer;
        end
      end

      if (too_long) begin
        len_err_cnt <= len_err_cnt + 16'd1;
      end

      if (frame_end) begin
        if (byte_cnt < MIN_CNT) begin
          len_err_cnt <= len_err_cnt + 16'd1;
        end else if (crc != RESIDUE) begin
          crc_err_cnt <= crc_err_cnt + 16'd1;
        end else begin
          good_cnt <= good_cnt + 16'd1;
          if (magic_word == MAGIC) begin
            latency   <= t_arr - stamp;
            lat_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_probe_rx.sv
// tb_gmii_probe_rx: scoreboard bench for gmii_probe_rx.
// The stimulus process queues the expected latency reports.
// The monitor process checks lat_valid pulses as they appear.
// It also runs the counter snapshots the stimulus process asks for.
module tb_gmii_probe_rx;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rx_dv;
  logic [7:0]  rx_data;
  logic [31:0] timer;
  logic [31:0] latency;
  logic        lat_valid;
  logic [15:0] good_cnt;
  logic [15:0] crc_err_cnt;
  logic [15:0] len_err_cnt;

  gmii_probe_rx dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .timer       (timer),
    .latency     (latency),
    .lat_valid   (lat_valid),
    .good_cnt    (good_cnt),
    .crc_err_cnt (crc_err_cnt),
    .len_err_cnt (len_err_cnt)
  );

  typedef struct packed {
    logic [31:0] lat;
    int          fall_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  txq[$];
  int          sof;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          req_id = 0;
  int          done_id = 0;
  string       req_name = "";
  bit          finish_req = 1'b0;
  logic [15:0] exp_good = 16'd0;
  logic [15:0] exp_crc = 16'd0;
  logic [15:0] exp_len = 16'd0;
  logic [31:0] exp_latency = 32'd0;

  // 125 MHz GMII receive clock
  always #4 clock = ~clock;

  // Cycle index, used to time lat_valid against the fall of rx_dv
  always @(posedge clock) cyc <= cyc + 1;

  // Reference CRC-32, reflected, one byte at a time
  function automatic logic [31:0] crcByte(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Builds preamble, SFD, payload (magic at 42, stamp at 46) and FCS into txq
  task automatic buildFrame(input int len, input logic [31:0] mg, input logic [31:0] st,
                            input int flip, input int pre_n, input bit bad_pre);
    logic [31:0] c;
    logic [31:0] fcs;
    logic [7:0]  b;
    txq.delete();
    for (int p = 0; p < pre_n; p++) txq.push_back((bad_pre && p == 3) ? 8'h5A : 8'h55);
    txq.push_back(8'hD5);
    sof = pre_n + 1;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < len - 4; i++) begin
      b = 8'(i) ^ 8'h3C;
      if (i >= 42 && i < 46) b = mg[8*(45-i) +: 8];
      if (i >= 46 && i < 50) b = st[8*(49-i) +: 8];
      c = crcByte(c, b);
      txq.push_back(b);
    end
    fcs = ~c;
    for (int k = 0; k < 4; k++) txq.push_back(fcs[8*k +: 8]);
    if (flip >= 0) txq[sof + flip] = txq[sof + flip] ^ 8'h01;
  endtask

  // Sends txq. The timer reads t_target on frame byte 49.
  // Reset can be pulsed mid-frame. The expected latency report is queued when rx_dv falls.
  task automatic applyStimulus(input logic [31:0] t_target, input int idle_n, input int rst_at,
                               input bit want_lat, input logic [31:0] lat);
    exp_t e;
    for (int i = 0; i < txq.size(); i++) begin
      @(posedge clock);
      #1;
      rx_dv   = 1'b1;
      rx_data = txq[i];
      timer   = t_target + 32'(i - sof - 49);
      if (rst_at >= 0 && i == rst_at) reset_n = 1'b0;
      if (rst_at >= 0 && i == rst_at + 3) reset_n = 1'b1;
    end
    @(posedge clock);
    #1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    timer   = timer + 32'd1;
    if (want_lat) begin
      e.lat      = lat;
      e.fall_cyc = cyc;
      exp_q.push_back(e);
      exp_latency = lat;
    end
    repeat (idle_n - 1) begin
      @(posedge clock);
      #1;
      timer = timer + 32'd1;
    end
  endtask

  // Asks the monitor for a counter/latency snapshot and waits until it is taken
  task automatic requestCheck(input string name);
    req_name = name;
    req_id   = req_id + 1;
    repeat (2) @(posedge clock);
  endtask

  // Compares the steady-state outputs against the bench model
  task automatic checkOutput(input string name);
    checks++;
    if (good_cnt !== exp_good) begin
      errors++;
      $display("[TB] FAIL %s good_cnt got %h expected %h", name, good_cnt, exp_good);
    end
    checks++;
    if (crc_err_cnt !== exp_crc) begin
      errors++;
      $display("[TB] FAIL %s crc_err_cnt got %h expected %h", name, crc_err_cnt, exp_crc);
    end
    checks++;
    if (len_err_cnt !== exp_len) begin
      errors++;
      $display("[TB] FAIL %s len_err_cnt got %h expected %h", name, len_err_cnt, exp_len);
    end
    checks++;
    if (latency !== exp_latency) begin
      errors++;
      $display("[TB] FAIL %s latency got %h expected %h", name, latency, exp_latency);
    end
    checks++;
    if (lat_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s lat_valid got %b expected 0", name, lat_valid);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s missing_lat_valid pending %0d expected 0", name, exp_q.size());
    end
  endtask

  // Monitor: scores lat_valid pulses, serves snapshot requests and ends the run
  always @(negedge clock) begin
    exp_t e;
    if (reset_n === 1'b1 && lat_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_lat_valid latency got %h expected no pulse", latency);
      end else begin
        e = exp_q.pop_front();
        if (latency !== e.lat) begin
          errors++;
          $display("[TB] FAIL lat_value latency got %h expected %h", latency, e.lat);
        end
        checks++;
        if ((cyc - e.fall_cyc) < 1 || (cyc - e.fall_cyc) > 2) begin
          errors++;
          $display("[TB] FAIL lat_timing delay got %0d cycles expected 1..2", cyc - e.fall_cyc);
        end
      end
    end
    if (req_id != done_id) begin
      checkOutput(req_name);
      done_id = req_id;
    end
    if (finish_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("[TB] FAIL final_pending lat reports got %0d expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  // Directed stimulus sequence
  initial begin
    reset_n = 1'b0;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    timer   = 32'd0;
    repeat (3) @(posedge clock);
    requestCheck("reset_state");
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);

    $display("[TB] good probe");
    buildFrame(64, 32'hDEADBEEF, 32'h00001000, -1, 7, 1'b0);
    applyStimulus(32'h00001234, 4, -1, 1'b1, 32'h00000234);
    exp_good = 16'd1;
    requestCheck("good_probe");

    $display("[TB] corrupted byte 20");
    buildFrame(64, 32'hDEADBEEF, 32'h00001000, 20, 7, 1'b0);
    applyStimulus(32'h00001234, 4, -1, 1'b0, 32'd0);
    exp_crc = 16'd1;
    requestCheck("crc_error");

    $display("[TB] short and long frames");
    buildFrame(40, 32'hDEADBEEF, 32'h00001000, -1, 7, 1'b0);
    applyStimulus(32'h00001234, 4, -1, 1'b0, 32'd0);
    exp_len = 16'd1;
    requestCheck("short_frame");
    buildFrame(1600, 32'hDEADBEEF, 32'h00001000, -1, 7, 1'b0);
    applyStimulus(32'h00001234, 4, -1, 1'b0, 32'd0);
    exp_len = 16'd2;
    requestCheck("long_frame");

    $display("[TB] timer wrap then back-to-back foreign magic");
    buildFrame(64, 32'hDEADBEEF, 32'hFFFFFFF0, -1, 7, 1'b0);
    applyStimulus(32'h00000010, 1, -1, 1'b1, 32'h00000020);
    buildFrame(64, 32'hCAFEBABE, 32'h00000100, -1, 7, 1'b0);
    applyStimulus(32'h00000500, 4, -1, 1'b0, 32'd0);
    exp_good = 16'd3;
    requestCheck("wrap_and_b2b");

    $display("[TB] bad and overlong preambles");
    buildFrame(64, 32'hDEADBEEF, 32'h00000100, -1, 7, 1'b1);
    applyStimulus(32'h00000300, 4, -1, 1'b0, 32'd0);
    requestCheck("bad_preamble");
    buildFrame(64, 32'hDEADBEEF, 32'h00000100, -1, 8, 1'b0);
    applyStimulus(32'h00000300, 4, -1, 1'b0, 32'd0);
    requestCheck("preamble_8");
    buildFrame(64, 32'hDEADBEEF, 32'h00000040, -1, 1, 1'b0);
    applyStimulus(32'h00000047, 4, -1, 1'b1, 32'h00000007);
    exp_good = 16'd4;
    requestCheck("preamble_1");

    $display("[TB] reset mid-frame");
    buildFrame(64, 32'hDEADBEEF, 32'h00000100, -1, 7, 1'b0);
    applyStimulus(32'h00000900, 4, 20, 1'b0, 32'd0);
    exp_good    = 16'd0;
    exp_crc     = 16'd0;
    exp_len     = 16'd0;
    exp_latency = 32'd0;
    requestCheck("reset_mid_frame");
    buildFrame(64, 32'hDEADBEEF, 32'h00002000, -1, 7, 1'b0);
    applyStimulus(32'h00002500, 4, -1, 1'b1, 32'h00000500);
    exp_good = 16'd1;
    requestCheck("probe_after_reset");

    finish_req = 1'b1;
    repeat (4) @(posedge clock);
    $display("[TB] FAIL monitor_finish got no summary expected summary");
    $fatal(1, "[TB] monitor did not end the run");
  end

endmodule
